// File: rtl/smi_mem_lib_write_burst.sv
`default_nettype none
// ============================================================================
// Module   : smi_mem_lib_write_burst
// Purpose  : SMI memory-library write initiator for bursts of 1..MAX_WORDS
//            32-bit words. Takes a parameter tuple plus a word stream, emits
//            one SMI write request frame (payload packed at a 16-bit offset),
//            waits for the write response and reports a status code.
// Ports    : clk, arst_n                  clock, async active-low reset
//            params* (Valid/Stop)         address, option byte, length N
//            data*   (Valid/Stop)         payload words, word 0 first
//            done*   (Valid/Stop)         completion with Ok flag and code
//                                         (0 ok, 1 resp error, 2 bad id, 3 bad len)
//            smiReq* (Valid/Stop)         request flits out, eofc on last
//            smiResp*(Valid/Stop)         response flits in
// Revision : 1.0 - initial release
// ============================================================================
module smi_mem_lib_write_burst #(
    parameter int MAX_WORDS = 64,
    parameter int LEN_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 paramsValid,
    input  logic [63:0]          paramWriteAddr,
    input  logic [7:0]           paramWriteOpts,
    input  logic [LEN_WIDTH-1:0] paramWriteLen,
    output logic                 paramsStop,
    input  logic                 dataValid,
    input  logic [31:0]          dataWord,
    output logic                 dataStop,
    output logic                 doneValid,
    output logic                 doneStatusOk,
    output logic [1:0]           doneStatusCode,
    input  logic                 doneStop,
    output logic                 smiReqValid,
    output logic [7:0]           smiReqEofc,
    output logic [63:0]          smiReqData,
    input  logic                 smiReqStop,
    input  logic                 smiRespValid,
    input  logic [7:0]           smiRespEofc,
    input  logic [63:0]          smiRespData,
    output logic                 smiRespStop
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HDR1       = 3'd1,
        ST_HDR2       = 3'd2,
        ST_DATA       = 3'd3,
        ST_RESP_WAIT  = 3'd4,
        ST_RESP_DRAIN = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_maxLen = LEN_WIDTH'(MAX_WORDS);
    localparam logic [LEN_WIDTH-1:0] c_one    = LEN_WIDTH'(1);

    state_t               r_state;
    state_t               w_stateNext;
    logic [63:2]          r_addr;
    logic [7:0]           r_opts;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_remain;      // words not yet consumed
    logic [31:0]          r_hold;        // first word of a pair awaiting its partner
    logic                 r_holdValid;
    logic [15:0]          r_carry;       // upper half of the last consumed word
    logic                 r_reqValid;
    logic [7:0]           r_reqEofc;
    logic [63:0]          r_reqData;
    logic                 r_doneValid;
    logic                 r_doneOk;
    logic [1:0]           r_doneCode;

    logic                 w_slotFree;
    logic                 w_lenBad;
    logic [15:0]          w_byteLen;
    logic                 w_paramsAccept;
    logic                 w_dataReady;
    logic                 w_dataTake;
    logic                 w_reqLoad;
    logic [63:0]          w_reqDataNext;
    logic [7:0]           w_reqEofcNext;
    logic                 w_holdLoad;
    logic                 w_holdClear;
    logic                 w_carryLoad;
    logic                 w_respCheck;
    logic                 w_respReady;
    logic                 w_doneSet;
    logic                 w_doneAck;
    logic                 w_unusedRespBits;

    // The output flit register may be refilled when empty or being drained.
    assign w_slotFree = ~r_reqValid | ~smiReqStop;
    assign w_lenBad   = (paramWriteLen == '0) || (paramWriteLen > c_maxLen);
    assign w_byteLen  = 16'({r_len, 2'b00});
    assign w_dataTake = w_dataReady & dataValid;
    assign w_unusedRespBits = ^{smiRespData[63:10], smiRespData[8]};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_paramsAccept = 1'b0;
        w_dataReady    = 1'b0;
        w_reqLoad      = 1'b0;
        w_reqDataNext  = '0;
        w_reqEofcNext  = '0;
        w_holdLoad     = 1'b0;
        w_holdClear    = 1'b0;
        w_carryLoad    = 1'b0;
        w_respCheck    = 1'b0;
        w_respReady    = 1'b0;
        w_doneSet      = 1'b0;
        w_doneAck      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (paramsValid) begin
                    w_paramsAccept = 1'b1;
                    w_stateNext    = w_lenBad ? ST_DONE : ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (w_slotFree) begin
                    w_reqLoad     = 1'b1;
                    w_reqDataNext = {r_addr[31:2], 18'd0, r_opts, 8'h01};
                    w_stateNext   = ST_HDR2;
                end
            end
            ST_HDR2: begin
                w_dataReady = w_slotFree;
                if (w_slotFree && dataValid) begin
                    w_reqLoad     = 1'b1;
                    w_reqDataNext = {dataWord[15:0], w_byteLen, r_addr[63:32]};
                    w_carryLoad   = 1'b1;
                    w_stateNext   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_holdValid) begin
                    // Second word of a pair completes a full 8-byte flit.
                    w_dataReady = w_slotFree;
                    if (w_slotFree && dataValid) begin
                        w_reqLoad     = 1'b1;
                        w_reqDataNext = {dataWord[15:0], r_hold, r_carry};
                        w_carryLoad   = 1'b1;
                        w_holdClear   = 1'b1;
                    end
                end else if (r_remain > c_one) begin
                    w_dataReady = 1'b1;
                    w_holdLoad  = dataValid;
                end else if (r_remain == c_one) begin
                    // Even N: last word plus carry, six valid bytes.
                    w_dataReady = w_slotFree;
                    if (w_slotFree && dataValid) begin
                        w_reqLoad     = 1'b1;
                        w_reqDataNext = {16'd0, dataWord, r_carry};
                        w_reqEofcNext = 8'd6;
                        w_stateNext   = ST_RESP_WAIT;
                    end
                end else if (w_slotFree) begin
                    // Odd N: only the carried half-word remains.
                    w_reqLoad     = 1'b1;
                    w_reqDataNext = {48'd0, r_carry};
                    w_reqEofcNext = 8'd2;
                    w_stateNext   = ST_RESP_WAIT;
                end
            end
            ST_RESP_WAIT: begin
                if (smiRespValid) begin
                    w_respCheck = 1'b1;
                    w_stateNext = ST_RESP_DRAIN;
                end
            end
            ST_RESP_DRAIN: begin
                w_respReady = 1'b1;
                if (smiRespValid && (smiRespEofc != 8'd0)) begin
                    w_doneSet   = 1'b1;
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!doneStop) begin
                    w_doneAck   = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr      <= '0;
            r_opts      <= '0;
            r_len       <= '0;
            r_remain    <= '0;
            r_hold      <= '0;
            r_holdValid <= 1'b0;
            r_carry     <= '0;
            r_reqValid  <= 1'b0;
            r_reqEofc   <= '0;
            r_reqData   <= '0;
            r_doneValid <= 1'b0;
            r_doneOk    <= 1'b0;
            r_doneCode  <= '0;
        end else begin
            if (w_paramsAccept) begin
                r_addr      <= paramWriteAddr[63:2];
                r_opts      <= paramWriteOpts;
                r_len       <= paramWriteLen;
                r_remain    <= paramWriteLen;
                r_holdValid <= 1'b0;
                if (w_lenBad) begin
                    r_doneValid <= 1'b1;
                    r_doneOk    <= 1'b0;
                    r_doneCode  <= 2'd3;
                end
            end
            if (w_dataTake) begin
                r_remain <= r_remain - c_one;
            end
            if (w_holdLoad) begin
                r_hold      <= dataWord;
                r_holdValid <= 1'b1;
            end else if (w_holdClear) begin
                r_holdValid <= 1'b0;
            end
            if (w_carryLoad) begin
                r_carry <= dataWord[31:16];
            end
            if (w_reqLoad) begin
                r_reqValid <= 1'b1;
                r_reqData  <= w_reqDataNext;
                r_reqEofc  <= w_reqEofcNext;
            end else if (!smiReqStop) begin
                r_reqValid <= 1'b0;
            end
            // Status is judged on the first response flit without popping it.
            if (w_respCheck) begin
                if (smiRespData[7:0] == 8'hFE) begin
                    r_doneOk   <= ~smiRespData[9];
                    r_doneCode <= smiRespData[9] ? 2'd1 : 2'd0;
                end else begin
                    r_doneOk   <= 1'b0;
                    r_doneCode <= 2'd2;
                end
            end
            if (w_doneSet) begin
                r_doneValid <= 1'b1;
            end else if (w_doneAck) begin
                r_doneValid <= 1'b0;
            end
        end
    end

    // Params are only ever accepted on the Idle exit; forced off in reset.
    assign paramsStop     = ~(arst_n & (r_state == ST_IDLE) & paramsValid);
    assign dataStop       = ~w_dataReady;
    assign smiRespStop    = ~w_respReady;
    assign smiReqValid    = r_reqValid;
    assign smiReqEofc     = r_reqEofc;
    assign smiReqData     = r_reqData;
    assign doneValid      = r_doneValid;
    assign doneStatusOk   = r_doneOk;
    assign doneStatusCode = r_doneCode;

endmodule
`default_nettype wire

// File: tb/tb_smi_mem_lib_write_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_smi_mem_lib_write_burst
// Purpose  : Directed self-checking bench for smi_mem_lib_write_burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smi_mem_lib_write_burst;

    localparam int MAXW = 64;
    localparam int LW   = 7;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          paramsValid;
    logic [63:0]   paramWriteAddr;
    logic [7:0]    paramWriteOpts;
    logic [LW-1:0] paramWriteLen;
    logic          paramsStop;
    logic          dataValid;
    logic [31:0]   dataWord;
    logic          dataStop;
    logic          doneValid;
    logic          doneStatusOk;
    logic [1:0]    doneStatusCode;
    logic          doneStop;
    logic          smiReqValid;
    logic [7:0]    smiReqEofc;
    logic [63:0]   smiReqData;
    logic          smiReqStop;
    logic          smiRespValid;
    logic [7:0]    smiRespEofc;
    logic [63:0]   smiRespData;
    logic          smiRespStop;

    always #5 clk = ~clk;

    smi_mem_lib_write_burst #(.MAX_WORDS(MAXW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .arst_n(arst_n),
        .paramsValid(paramsValid), .paramWriteAddr(paramWriteAddr),
        .paramWriteOpts(paramWriteOpts), .paramWriteLen(paramWriteLen),
        .paramsStop(paramsStop),
        .dataValid(dataValid), .dataWord(dataWord), .dataStop(dataStop),
        .doneValid(doneValid), .doneStatusOk(doneStatusOk),
        .doneStatusCode(doneStatusCode), .doneStop(doneStop),
        .smiReqValid(smiReqValid), .smiReqEofc(smiReqEofc),
        .smiReqData(smiReqData), .smiReqStop(smiReqStop),
        .smiRespValid(smiRespValid), .smiRespEofc(smiRespEofc),
        .smiRespData(smiRespData), .smiRespStop(smiRespStop)
    );

    logic [31:0] dArr [0:127];
    int          dN, dIdx;
    logic [71:0] rArr [0:7];
    int          rN, rIdx;
    logic [71:0] reqQ [$];
    int          doneCnt;
    logic        lastOk;
    logic [1:0]  lastCode;
    int          rIdxAtDone;
    bit          gaps, stopRand;
    int          total, bad;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: observe transfers at the negedge, update drivers after posedge.
    task automatic tick();
        bit dT, rT, pT;
        @(negedge clk);
        dT = dataValid && !dataStop;
        rT = smiRespValid && !smiRespStop;
        pT = paramsValid && !paramsStop;
        if (arst_n && smiReqValid && !smiReqStop) reqQ.push_back({smiReqEofc, smiReqData});
        if (arst_n && doneValid && !doneStop) begin
            doneCnt++;
            lastOk     = doneStatusOk;
            lastCode   = doneStatusCode;
            rIdxAtDone = rIdx;
        end
        @(posedge clk);
        #2;
        if (dT) dIdx++;
        if (rT) rIdx++;
        if (pT) paramsValid = 1'b0;
        if (!(dataValid && !dT)) begin
            if (dIdx < dN && !(gaps && $urandom_range(0, 2) == 0)) begin
                dataValid = 1'b1;
                dataWord  = dArr[dIdx];
            end else begin
                dataValid = 1'b0;
            end
        end
        if (rIdx < rN) begin
            smiRespValid = 1'b1;
            {smiRespEofc, smiRespData} = rArr[rIdx];
        end else begin
            smiRespValid = 1'b0;
        end
        smiReqStop = stopRand ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic startBurst(input logic [63:0] a, input logic [7:0] o, input logic [LW-1:0] n);
        reqQ.delete();
        dIdx           = 0;
        rIdx           = 0;
        dataValid      = 1'b0;
        smiRespValid   = 1'b0;
        paramWriteAddr = a;
        paramWriteOpts = o;
        paramWriteLen  = n;
        paramsValid    = 1'b1;
    endtask

    task automatic runUntilDone(input string tag, input int limit);
        int start;
        int n;
        start = doneCnt;
        n     = 0;
        while (doneCnt == start && n < limit) begin
            tick();
            n++;
        end
        chk({tag, " done seen"}, 128'(doneCnt - start), 128'd1);
    endtask

    task automatic expFlit(input string tag, input logic [71:0] exp);
        logic [71:0] got;
        if (reqQ.size() > 0) got = reqQ.pop_front();
        else                 got = {72{1'bx}};
        chk(tag, got, exp);
    endtask

    function automatic logic [31:0] patWord(input int i);
        return {8'(i), 8'hC3, 8'(255 - i), 8'h3C};
    endfunction

    function automatic logic [15:0] half(input int h, input int n);
        logic [31:0] w;
        if (h >= 2 * n) return 16'h0000;
        w = dArr[h / 2];
        return (h % 2 == 1) ? w[31:16] : w[15:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0; bad = 0; doneCnt = 0; rIdxAtDone = 0;
        lastOk = 1'b0; lastCode = 2'd0;
        gaps = 1'b0; stopRand = 1'b0;
        dN = 0; rN = 0; dIdx = 0; rIdx = 0;
        arst_n = 1'b0;
        paramsValid = 1'b1; paramWriteAddr = '0; paramWriteOpts = '0; paramWriteLen = '0;
        dataValid = 1'b0; dataWord = '0; doneStop = 1'b0;
        smiReqStop = 1'b0; smiRespValid = 1'b0; smiRespEofc = '0; smiRespData = '0;
        #1;
        // {reqValid, doneValid, ok, code, paramsStop, dataStop, respStop, eofc, data}
        chk("reset state", {smiReqValid, doneValid, doneStatusOk, doneStatusCode,
                            paramsStop, dataStop, smiRespStop, smiReqEofc, smiReqData},
            {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'd0, 64'd0});
        paramsValid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        arst_n = 1'b1;
        tick();

        // N=1, single-flit OK response, completion held off by doneStop.
        dArr[0] = 32'hDEADBEEF; dN = 1;
        rArr[0] = {8'd1, 64'h00FE}; rN = 1;
        doneStop = 1'b1;
        startBurst(64'h0000_0001_2345_6788, 8'h0C, 7'd1);
        n = 0;
        while (!doneValid && n < 60) begin tick(); n++; end
        repeat (3) tick();
        chk("n1 done held", {doneValid, doneStatusOk, doneStatusCode, paramsStop}, {1'b1, 1'b1, 2'd0, 1'b1});
        doneStop = 1'b0;
        runUntilDone("n1", 10);
        chk("n1 flit count", 128'(reqQ.size()), 128'd3);
        expFlit("n1 hdr1",  {8'd0, 64'h2345_6788_0000_0C01});
        expFlit("n1 hdr2",  {8'd0, 64'hBEEF_0004_0000_0001});
        expFlit("n1 final", {8'd2, 64'h0000_0000_0000_DEAD});
        chk("n1 status", {lastOk, lastCode}, {1'b1, 2'd0});
        chk("n1 resp popped", 128'(rIdx), 128'd1);

        // N=4, response with error bit set.
        dArr[0] = 32'h11111111; dArr[1] = 32'h22222222;
        dArr[2] = 32'h33333333; dArr[3] = 32'h44444444; dN = 4;
        rArr[0] = {8'd1, 64'h02FE}; rN = 1;
        startBurst(64'h0000_0000_8000_0004, 8'hA5, 7'd4);
        runUntilDone("n4", 80);
        chk("n4 flit count", 128'(reqQ.size()), 128'd4);
        expFlit("n4 hdr1",  {8'd0, 64'h8000_0004_0000_A501});
        expFlit("n4 hdr2",  {8'd0, 64'h1111_0010_0000_0000});
        expFlit("n4 flit3", {8'd0, 64'h3333_2222_2222_1111});
        expFlit("n4 flit4", {8'd6, 64'h0000_4444_4444_3333});
        chk("n4 status", {lastOk, lastCode}, {1'b0, 2'd1});

        // N=3 under random request backpressure and data gaps, bad response id.
        dArr[0] = 32'hA1A2A3A4; dArr[1] = 32'hB1B2B3B4; dArr[2] = 32'hC1C2C3C4; dN = 3;
        rArr[0] = {8'd1, 64'h00AA}; rN = 1;
        gaps = 1'b1; stopRand = 1'b1;
        startBurst(64'h0000_0000_0000_1000, 8'h00, 7'd3);
        runUntilDone("n3", 200);
        gaps = 1'b0; stopRand = 1'b0;
        chk("n3 flit count", 128'(reqQ.size()), 128'd4);
        expFlit("n3 hdr1",  {8'd0, 64'h0000_1000_0000_0001});
        expFlit("n3 hdr2",  {8'd0, 64'hA3A4_000C_0000_0000});
        expFlit("n3 flit3", {8'd0, 64'hC3C4_B1B2_B3B4_A1A2});
        expFlit("n3 final", {8'd2, 64'h0000_0000_0000_C1C2});
        chk("n3 words taken", 128'(dIdx), 128'd3);
        chk("n3 status", {lastOk, lastCode}, {1'b0, 2'd2});

        // Three-flit response must be fully drained before completion.
        dArr[0] = 32'h12345678; dN = 1;
        rArr[0] = {8'd0, 64'h00FE}; rArr[1] = {8'd0, 64'h1111}; rArr[2] = {8'd8, 64'h2222}; rN = 3;
        startBurst(64'h0000_0002_0000_0010, 8'h33, 7'd1);
        runUntilDone("resp3", 60);
        expFlit("resp3 hdr1",  {8'd0, 64'h0000_0010_0000_3301});
        expFlit("resp3 hdr2",  {8'd0, 64'h5678_0004_0000_0002});
        expFlit("resp3 final", {8'd2, 64'h0000_0000_0000_1234});
        chk("resp3 drained", 128'(rIdxAtDone), 128'd3);
        chk("resp3 status", {lastOk, lastCode}, {1'b1, 2'd0});

        // Zero length: nothing issued, no data or response consumed.
        dArr[0] = 32'h0BAD0BAD; dArr[1] = 32'h0BAD0BAD; dN = 2;
        rArr[0] = {8'd1, 64'h00FE}; rN = 1;
        startBurst(64'h0000_0000_0000_2000, 8'h01, 7'd0);
        runUntilDone("len0", 20);
        chk("len0 no req", 128'(reqQ.size()), 128'd0);
        chk("len0 no data/resp", {dataStop, 32'(dIdx), 32'(rIdx)}, {1'b1, 32'd0, 32'd0});
        chk("len0 status", {lastOk, lastCode}, {1'b0, 2'd3});

        // MAX_WORDS+1: rejected the same way.
        startBurst(64'h0000_0000_0000_2000, 8'h01, 7'(MAXW + 1));
        runUntilDone("len65", 20);
        chk("len65 no req", 128'(reqQ.size()), 128'd0);
        chk("len65 no data/resp", {dataStop, 32'(dIdx), 32'(rIdx)}, {1'b1, 32'd0, 32'd0});
        chk("len65 status", {lastOk, lastCode}, {1'b0, 2'd3});

        // Full-length burst: 2 header flits + 32 data flits.
        for (int i = 0; i < MAXW; i++) dArr[i] = patWord(i);
        dN = MAXW;
        rArr[0] = {8'd1, 64'h00FE}; rN = 1;
        startBurst(64'h0000_0000_0000_0100, 8'h00, 7'(MAXW));
        runUntilDone("max", 400);
        chk("max flit count", 128'(reqQ.size()), 128'd34);
        expFlit("max hdr1", {8'd0, 64'h0000_0100_0000_0001});
        expFlit("max hdr2", {8'd0, half(0, MAXW), 16'h0100, 32'h0});
        for (int j = 0; j < 32; j++) begin
            expFlit($sformatf("max data%0d", j),
                    {(j == 31) ? 8'd6 : 8'd0,
                     half(4 * j + 4, MAXW), half(4 * j + 3, MAXW),
                     half(4 * j + 2, MAXW), half(4 * j + 1, MAXW)});
        end
        chk("max status", {lastOk, lastCode}, {1'b1, 2'd0});

        // Asynchronous reset in the middle of the data phase.
        dArr[0] = 32'h11111111; dArr[1] = 32'h22222222;
        dArr[2] = 32'h33333333; dArr[3] = 32'h44444444; dN = 4;
        rN = 0;
        doneStop = 1'b1;
        startBurst(64'h0000_0000_8000_0004, 8'hA5, 7'd4);
        n = 0;
        while (reqQ.size() < 2 && n < 50) begin tick(); n++; end
        chk("rst reached data", 128'(reqQ.size()), 128'd2);
        tick();
        #1;
        arst_n = 1'b0;
        paramsValid = 1'b1;
        #1;
        chk("rst mid-data", {smiReqValid, doneValid, doneStatusOk, doneStatusCode,
                             paramsStop, dataStop, smiRespStop, smiReqEofc, smiReqData},
            {1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'd0, 64'd0});
        paramsValid = 1'b0; dataValid = 1'b0; dN = 0; smiRespValid = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        doneStop = 1'b0;
        tick();
        dArr[0] = 32'hA1A2A3A4; dArr[1] = 32'hB1B2B3B4; dArr[2] = 32'hC1C2C3C4; dN = 3;
        rArr[0] = {8'd1, 64'h00FE}; rN = 1;
        startBurst(64'h0000_0000_0000_1000, 8'h00, 7'd3);
        runUntilDone("post", 80);
        chk("post flit count", 128'(reqQ.size()), 128'd4);
        expFlit("post hdr1",  {8'd0, 64'h0000_1000_0000_0001});
        expFlit("post hdr2",  {8'd0, 64'hA3A4_000C_0000_0000});
        expFlit("post flit3", {8'd0, 64'hC3C4_B1B2_B3B4_A1A2});
        expFlit("post final", {8'd2, 64'h0000_0000_0000_C1C2});
        chk("post status", {lastOk, lastCode}, {1'b1, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
